rv_multicycle_ctrl: RTL
=======================

Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback phases per instruction.
- Drives the ALUOp/Funct pair consumed by ALU_Control, plus the datapath enables for register file, memory and PC.
- Stalls on a memory ready handshake; traps on unsupported opcodes.

Parameters:
- MAX_WAIT, 16, memory wait cycles tolerated before the bus-timeout error is raised.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- ALUOp  out  2  to ALU_Control.
- Funct  out  4  to ALU_Control: {funct7_5, funct3}.
- ALUSrcA  out  1  0=PC, 1=rs1.
- ALUSrcB  out  2  00=rs2, 01=const 4, 10=immediate.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  write PC.
- PCSrc  out  1  0=ALU result, 1=branch target register.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write.
- MemtoReg  out  1  writeback source: 1=MDR.
- illegal  out  1  sticky: unsupported opcode trapped.
- bus_err  out  1  sticky: mem_ready timeout.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset (async, reset_n=0):
  - state=FETCH, so outputs take FETCH values once reset_n is released.
  - While reset_n=0, all enables/strobes are 0, ALUOp=00, Funct=0000, illegal=0, bus_err=0, wait counter=0.
  - Reset asserted mid-access aborts the access; no write is completed.
- Outputs are a Moore decode of state, except Funct, which is combinational from the IR fields.
- Funct is forced to 0000 whenever ALUOp≠10, and to {1'b0,funct3} in EXEC_I (no subtract-immediate).
- FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - On mem_ready: IRWrite=1, PCWrite=1 (PC+4), go to DECODE.
  - Otherwise hold state.
- DECODE: ALUOp=00, ALUSrcA=0, ALUSrcB=10 (branch target precompute). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - any other → TRAP
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=10; next ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0; next FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM_RD (load) or MEM_WR (store).
- MEM_RD: MemRead=1; on mem_ready go to MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1; next FETCH.
- MEM_WR: MemWrite=1; on mem_ready go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1. Branch taken when (funct3=000 & zero) | (funct3=001 & ~zero).
  - PCWrite = taken.
  - Next FETCH.
- TRAP: illegal=1, all enables 0; stays until reset.
- Wait counter:
  - Counts consecutive cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0; clears on any state change.
  - When the count reaches MAX_WAIT: bus_err=1, go to TRAP.
  - If mem_ready rises on the same cycle the limit is hit, mem_ready wins and no error is raised.
- Latency per instruction with mem_ready every cycle:
  - R/I: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Unused state encodings recover to FETCH.

Optional Feature:
- Macro: RV_CTRL_PERF_EN.
- Defined:
  - Adds outputs cycle_cnt[CNT_W] (increments every cycle out of reset) and retired_cnt[CNT_W] (increments on each transition into FETCH from ALU_WB, MEM_WB, MEM_WR or BRANCH).
  - Both counters reset to 0 and wrap at 2^CNT_W.
- Undefined: neither port nor the counters exist; remaining behaviour is identical.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state enumeration.
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH).
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10).
  - ALUSrcB select constants.
- One natural sub-module: rv_ctrl_wait_timer (the wait counter and timeout compare).

Test Plan:
- add (opcode 0110011, funct7_5=0, funct3=000), mem_ready=1 → states FETCH,DECODE,EXEC_R,ALU_WB; in EXEC_R ALUOp=10, Funct=0000; RegWrite=1 exactly one cycle.
- sub R-type (funct7_5=1) → Funct=1000 in EXEC_R; ori (0010011, funct3=110, funct7_5=1) → Funct=0110 in EXEC_I.
- lw with mem_ready low 3 cycles in MEM_RD → MemRead held 4 cycles; MEM_WB RegWrite=1, MemtoReg=1; total 8 cycles.
- beq with zero=1 → PCWrite=1, PCSrc=1 in BRANCH; same with zero=0 → PCWrite=0; bne inverts both results.
- opcode 1111111 → TRAP, illegal=1 held 20 cycles; reset_n pulse mid-TRAP → FETCH, illegal=0.
- mem_ready held 0 in FETCH for 16 cycles → bus_err=1, TRAP; repeat with mem_ready rising on cycle 16 → no error, DECODE.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      ALU_WB   = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      MEM_WB   = 4'd7,
      MEM_WR   = 4'd8,
      BRANCH   = 4'd9,
      TRAP     = 4'd10
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   // beq takes on zero, bne on non-zero; other funct3 codes never branch
   function automatic logic branch_taken(input logic [2:0] f3, input logic z);
      return ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
   endfunction

endpackage

// File: rtl/rv_ctrl_wait_timer.sv
// Memory-wait watchdog: counts consecutive stalled cycles in a wait state.
// Latency: timeout is combinational in the MAX_WAIT-th consecutive stalled cycle.
// Backpressure: a ready in the limit cycle suppresses the timeout; count clears when not stalled.
module rv_ctrl_wait_timer
   import rv_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic waiting,
   input  logic mem_ready,
   output logic timeout
);

   localparam int W = $clog2(MAX_WAIT + 1);

   logic [W-1:0] cnt;
   logic         stall;

   assign stall   = waiting && !mem_ready;
   assign timeout = stall && (cnt == W'(MAX_WAIT - 1));

   // a ready always moves the FSM on, so clearing on !stall is clearing on state change
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (stall && !timeout)
         cnt <= cnt + W'(1);
      else
         cnt <= '0;
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I datapath; RV_CTRL_PERF_EN adds cycle/retire counters.
// Latency: R/I 4, load 5, store 4, branch 3 cycles with ready memory.
// Backpressure: holds FETCH/MEM_RD/MEM_WR until mem_ready; traps with bus_err after MAX_WAIT stalls.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [1:0] ALUOp,
   output logic [3:0] Funct,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCSrc,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       MemtoReg,
   output logic       illegal,
   output logic       bus_err,
   output logic [3:0] state
`ifdef RV_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retired_cnt
`endif
);

   if (CNT_W < 1) begin : g_cnt_w_chk
      $error("CNT_W must be at least 1");
   end

   state_t     state_q, state_d;
   logic       waiting, timeout;
   logic [1:0] aluop_c, srcb_c;
   logic       srca_c, irw_c, pcw_c, pcsrc_c, mr_c, mw_c, rw_c, m2r_c;

   assign waiting = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

   rv_ctrl_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .waiting   (waiting),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FETCH;
         bus_err <= 1'b0;
      end else begin
         state_q <= state_d;
         if (timeout)
            bus_err <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      aluop_c = ALUOP_ADD;
      srca_c  = 1'b0;
      srcb_c  = SRCB_RS2;
      irw_c   = 1'b0;
      pcw_c   = 1'b0;
      pcsrc_c = 1'b0;
      mr_c    = 1'b0;
      mw_c    = 1'b0;
      rw_c    = 1'b0;
      m2r_c   = 1'b0;
      case (state_q)
         FETCH: begin
            mr_c   = 1'b1;
            srcb_c = SRCB_FOUR;
            if (mem_ready) begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               state_d = DECODE;
            end else if (timeout) begin
               state_d = TRAP;
            end
         end
         DECODE: begin
            srcb_c = SRCB_IMM;
            case (opcode)
               OP_R:               state_d = EXEC_R;
               OP_IMM:             state_d = EXEC_I;
               OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
               OP_BRANCH:          state_d = BRANCH;
               default:            state_d = TRAP;
            endcase
         end
         EXEC_R: begin
            srca_c  = 1'b1;
            aluop_c = ALUOP_FUNCT;
            state_d = ALU_WB;
         end
         EXEC_I: begin
            srca_c  = 1'b1;
            srcb_c  = SRCB_IMM;
            aluop_c = ALUOP_FUNCT;
            state_d = ALU_WB;
         end
         ALU_WB: begin
            rw_c    = 1'b1;
            state_d = FETCH;
         end
         MEM_ADDR: begin
            srca_c  = 1'b1;
            srcb_c  = SRCB_IMM;
            state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mr_c = 1'b1;
            if (mem_ready)    state_d = MEM_WB;
            else if (timeout) state_d = TRAP;
         end
         MEM_WB: begin
            rw_c    = 1'b1;
            m2r_c   = 1'b1;
            state_d = FETCH;
         end
         MEM_WR: begin
            mw_c = 1'b1;
            if (mem_ready)    state_d = FETCH;
            else if (timeout) state_d = TRAP;
         end
         BRANCH: begin
            srca_c  = 1'b1;
            aluop_c = ALUOP_SUB;
            pcsrc_c = 1'b1;
            pcw_c   = branch_taken(funct3, zero);
            state_d = FETCH;
         end
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   // strobes are gated so nothing fires while reset is held, even though state reads FETCH
   assign ALUOp    = reset_n ? aluop_c : 2'b00;
   assign ALUSrcA  = reset_n & srca_c;
   assign ALUSrcB  = reset_n ? srcb_c : 2'b00;
   assign IRWrite  = reset_n & irw_c;
   assign PCWrite  = reset_n & pcw_c;
   assign PCSrc    = reset_n & pcsrc_c;
   assign MemRead  = reset_n & mr_c;
   assign MemWrite = reset_n & mw_c;
   assign RegWrite = reset_n & rw_c;
   assign MemtoReg = reset_n & m2r_c;
   assign illegal  = reset_n & (state_q == TRAP);
   assign state    = state_q;

   // there is no subtract-immediate, so funct7_5 is dropped in EXEC_I
   always_comb begin
      Funct = 4'b0000;
      if (ALUOp == ALUOP_FUNCT)
         Funct = (state_q == EXEC_I) ? {1'b0, funct3} : {funct7_5, funct3};
   end

`ifdef RV_CTRL_PERF_EN
   logic retire;
   assign retire = (state_d == FETCH) &&
                   ((state_q == ALU_WB) || (state_q == MEM_WB) ||
                    (state_q == MEM_WR) || (state_q == BRANCH));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_cnt   <= '0;
         retired_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (retire)
            retired_cnt <= retired_cnt + CNT_W'(1);
      end
   end
`endif

endmodule
